// File: rtl/vram_arbiter.sv
// VRAM arbiter: shares one single-port SRAM between video scanout (priority)
// and the CPU bridge, with a bounded CPU starvation window.
module vram_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int CPU_MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  vid_req,
    input  logic [ADDR_WIDTH-1:0] vid_addr,
    output logic                  vid_gnt,
    output logic [DATA_WIDTH-1:0] vid_rdata,
    output logic                  vid_rvalid,

    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_gnt,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_rvalid,

    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [1:0] TAG_NONE = 2'd0;
    localparam logic [1:0] TAG_VID  = 2'd1;
    localparam logic [1:0] TAG_CPU  = 2'd2;
    localparam logic [3:0] MAX_WAIT = 4'(CPU_MAX_WAIT);

    logic [3:0]            r_cpu_wait;
    logic [1:0]            r_tag_s1;
    logic [1:0]            r_tag_s2;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_mem_we;
    logic [DATA_WIDTH-1:0] r_vid_rdata;
    logic                  r_vid_rvalid;
    logic [DATA_WIDTH-1:0] r_cpu_rdata;
    logic                  r_cpu_rvalid;

    logic                  w_cpu_gnt;
    logic                  w_vid_gnt;
    logic                  w_cpu_xfer;
    logic                  w_vid_xfer;
    logic [1:0]            w_issue_tag;

    // Grants are forced low during reset so no transfer can be seen then.
    always_comb begin
        w_cpu_gnt  = reset_n && cpu_req && (!vid_req || (r_cpu_wait >= MAX_WAIT));
        w_vid_gnt  = reset_n && vid_req && !w_cpu_gnt;
        w_cpu_xfer = cpu_req && w_cpu_gnt;
        w_vid_xfer = vid_req && w_vid_gnt;
        w_issue_tag = TAG_NONE;
        if (w_cpu_xfer && !cpu_we) begin
            w_issue_tag = TAG_CPU;
        end else if (w_vid_xfer) begin
            w_issue_tag = TAG_VID;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cpu_wait <= '0;
        end else if (cpu_req && !w_cpu_gnt) begin
            if (r_cpu_wait != 4'hF) begin
                r_cpu_wait <= r_cpu_wait + 4'd1;
            end
        end else begin
            r_cpu_wait <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
        end else if (w_cpu_xfer) begin
            r_mem_addr <= cpu_addr;
            r_mem_we   <= cpu_we;
            if (cpu_we) begin
                r_mem_wdata <= cpu_wdata;
            end
        end else if (w_vid_xfer) begin
            r_mem_addr <= vid_addr;
            r_mem_we   <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
        end
    end

    // Tag travels two stages to line up with SRAM read data arriving at E+2.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tag_s1     <= TAG_NONE;
            r_tag_s2     <= TAG_NONE;
            r_vid_rdata  <= '0;
            r_vid_rvalid <= 1'b0;
            r_cpu_rdata  <= '0;
            r_cpu_rvalid <= 1'b0;
        end else begin
            r_tag_s1     <= w_issue_tag;
            r_tag_s2     <= r_tag_s1;
            r_vid_rvalid <= (r_tag_s2 == TAG_VID);
            r_cpu_rvalid <= (r_tag_s2 == TAG_CPU);
            if (r_tag_s2 == TAG_VID) begin
                r_vid_rdata <= mem_rdata;
            end
            if (r_tag_s2 == TAG_CPU) begin
                r_cpu_rdata <= mem_rdata;
            end
        end
    end

    assign vid_gnt    = w_vid_gnt;
    assign cpu_gnt    = w_cpu_gnt;
    assign vid_rdata  = r_vid_rdata;
    assign vid_rvalid = r_vid_rvalid;
    assign cpu_rdata  = r_cpu_rdata;
    assign cpu_rvalid = r_cpu_rvalid;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_we     = r_mem_we;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: vector table plus scoreboard of expected read
// responses, with a behavioural SRAM and a CPU_MAX_WAIT=0 companion instance.
module tb_vram_arbiter;

    typedef struct {
        logic        vreq;
        logic [15:0] vaddr;
        logic        creq;
        logic        cwe;
        logic [15:0] caddr;
        logic [7:0]  cwd;
        logic        evg;
        logic        ecg;
    } vec_t;

    typedef struct {
        logic        is_cpu;
        logic [7:0]  data;
        int unsigned due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        vid_req = 1'b0;
    logic [15:0] vid_addr = '0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        vid_gnt, cpu_gnt, vid_rvalid, cpu_rvalid, mem_we;
    logic [7:0]  vid_rdata, cpu_rdata, mem_wdata;
    logic [7:0]  mem_rdata;
    logic [15:0] mem_addr;

    logic        z_vid_gnt, z_cpu_gnt, z_vid_rvalid, z_cpu_rvalid, z_mem_we;
    logic [7:0]  z_vid_rdata, z_cpu_rdata, z_mem_wdata;
    logic [15:0] z_mem_addr;
    logic [7:0]  z_mem_rdata = '0;

    logic        pre_we = 1'b0;
    logic [15:0] pre_addr = '0;
    logic [7:0]  pre_data = '0;
    logic [7:0]  sram   [0:65535];
    logic [7:0]  shadow [0:65535];

    int unsigned nvec = 0;
    int unsigned nmis = 0;
    int unsigned cyc = 0;
    exp_t        sb[$];
    vec_t        tbl[$];
    logic [15:0] m_addr = '0;
    logic [7:0]  m_wdata = '0;
    logic        m_we = 1'b0;
    logic [7:0]  m_vrd = '0;
    logic [7:0]  m_crd = '0;

    always #5 clk = ~clk;

    vram_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .CPU_MAX_WAIT(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
        .vid_rdata(vid_rdata), .vid_rvalid(vid_rvalid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata),
        .cpu_rvalid(cpu_rvalid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    vram_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .CPU_MAX_WAIT(0)) dut_z (
        .clk(clk), .reset_n(reset_n),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(z_vid_gnt),
        .vid_rdata(z_vid_rdata), .vid_rvalid(z_vid_rvalid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_gnt(z_cpu_gnt), .cpu_rdata(z_cpu_rdata),
        .cpu_rvalid(z_cpu_rvalid),
        .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata), .mem_we(z_mem_we),
        .mem_rdata(z_mem_rdata)
    );

    // Synchronous SRAM: data_out registered from the address sampled this edge.
    always @(posedge clk) begin
        if (pre_we) begin
            sram[pre_addr] <= pre_data;
        end else if (mem_we) begin
            sram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= sram[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic vr, input logic [15:0] va, input logic cr,
                                input logic we, input logic [15:0] ca, input logic [7:0] wd,
                                input logic evg, input logic ecg);
        vec_t v;
        v.vreq = vr; v.vaddr = va; v.creq = cr; v.cwe = we;
        v.caddr = ca; v.cwd = wd; v.evg = evg; v.ecg = ecg;
        return v;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_vid_gnt"}, vid_gnt, 0);
        chk({tag, "_cpu_gnt"}, cpu_gnt, 0);
        chk({tag, "_z_vid_gnt"}, z_vid_gnt, 0);
        chk({tag, "_z_cpu_gnt"}, z_cpu_gnt, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_vid_rdata"}, vid_rdata, 0);
        chk({tag, "_cpu_rdata"}, cpu_rdata, 0);
        chk({tag, "_vid_rvalid"}, vid_rvalid, 0);
        chk({tag, "_cpu_rvalid"}, cpu_rvalid, 0);
    endtask

    task automatic chk_outputs();
        exp_t e;
        logic ev, ec;
        ev = 1'b0;
        ec = 1'b0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            if (e.is_cpu) begin
                ec = 1'b1;
                m_crd = e.data;
            end else begin
                ev = 1'b1;
                m_vrd = e.data;
            end
        end
        chk("vid_rvalid", vid_rvalid, ev);
        chk("cpu_rvalid", cpu_rvalid, ec);
        chk("vid_rdata", vid_rdata, m_vrd);
        chk("cpu_rdata", cpu_rdata, m_crd);
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_we", mem_we, m_we);
        chk("mem_wdata", mem_wdata, m_wdata);
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic step(input vec_t v);
        exp_t e;
        vid_req = v.vreq; vid_addr = v.vaddr;
        cpu_req = v.creq; cpu_we = v.cwe; cpu_addr = v.caddr; cpu_wdata = v.cwd;
        @(negedge clk);
        chk("vid_gnt", vid_gnt, v.evg);
        chk("cpu_gnt", cpu_gnt, v.ecg);
        chk("z_cpu_gnt", z_cpu_gnt, v.creq);
        chk("z_vid_gnt", z_vid_gnt, v.vreq & ~v.creq);
        chk_outputs();
        @(posedge clk);
        cyc++;
        m_we = 1'b0;
        if (v.creq && v.ecg) begin
            m_addr = v.caddr;
            if (v.cwe) begin
                m_we = 1'b1;
                m_wdata = v.cwd;
                shadow[v.caddr] = v.cwd;
            end else begin
                e.is_cpu = 1'b1; e.data = shadow[v.caddr]; e.due = cyc + 2;
                sb.push_back(e);
            end
        end else if (v.vreq && v.evg) begin
            m_addr = v.vaddr;
            e.is_cpu = 1'b0; e.data = shadow[v.vaddr]; e.due = cyc + 2;
            sb.push_back(e);
        end
        #1;
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        shadow[a] = d;
        @(posedge clk);
        #1;
        pre_we = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(mk(0, '0, 0, 0, '0, '0, 0, 0));
    endtask

    initial begin
        #2 reset_n = 1'b0;
        preload(16'h7FFF, 8'h11);
        preload(16'h8000, 8'h22);
        preload(16'h8001, 8'h33);
        preload(16'h0100, 8'h5A);
        preload(16'h0200, 8'hC3);
        vid_req = 1'b1; cpu_req = 1'b1;
        #1 chk_all_zero("reset");
        vid_req = 1'b0; cpu_req = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Write then immediate read-back of the same address.
        tbl.push_back(mk(0, '0, 1, 1, 16'h1234, 8'hA5, 0, 1));
        tbl.push_back(mk(0, '0, 1, 0, 16'h1234, 8'h00, 0, 1));
        for (int i = 0; i < 2; i++) tbl.push_back(mk(0, '0, 0, 0, '0, '0, 0, 0));
        // Back-to-back video reads across the bank boundary.
        tbl.push_back(mk(1, 16'h7FFF, 0, 0, '0, '0, 1, 0));
        tbl.push_back(mk(1, 16'h8000, 0, 0, '0, '0, 1, 0));
        tbl.push_back(mk(1, 16'h8001, 0, 0, '0, '0, 1, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, '0, 0, 0, '0, '0, 0, 0));
        // Starvation bound: four refusals, CPU wins the fifth.
        tbl.push_back(mk(1, 16'h0100, 1, 0, 16'h0200, '0, 1, 0));
        tbl.push_back(mk(1, 16'h7FFF, 1, 0, 16'h0200, '0, 1, 0));
        tbl.push_back(mk(1, 16'h8000, 1, 0, 16'h0200, '0, 1, 0));
        tbl.push_back(mk(1, 16'h8001, 1, 0, 16'h0200, '0, 1, 0));
        tbl.push_back(mk(1, 16'h0100, 1, 0, 16'h0200, '0, 0, 1));
        tbl.push_back(mk(1, 16'h7FFF, 0, 0, '0, '0, 1, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, '0, 0, 0, '0, '0, 0, 0));
        // Dropping cpu_req clears the wait count.
        tbl.push_back(mk(1, 16'h8000, 1, 0, 16'h1234, '0, 1, 0));
        tbl.push_back(mk(1, 16'h8000, 1, 0, 16'h1234, '0, 1, 0));
        tbl.push_back(mk(1, 16'h8001, 0, 0, '0, '0, 1, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 16'h0100, 1, 0, 16'h1234, '0, 1, 0));
        tbl.push_back(mk(1, 16'h0200, 1, 0, 16'h1234, '0, 0, 1));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, '0, 0, 0, '0, '0, 0, 0));
        // Interleaved video / CPU reads.
        tbl.push_back(mk(1, 16'h0100, 0, 0, '0, '0, 1, 0));
        tbl.push_back(mk(0, '0, 1, 0, 16'h0200, '0, 0, 1));
        tbl.push_back(mk(1, 16'h0100, 0, 0, '0, '0, 1, 0));
        tbl.push_back(mk(0, '0, 1, 0, 16'h0200, '0, 0, 1));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, '0, 0, 0, '0, '0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // Reset one cycle after a CPU read transfer: that response must vanish.
        step(mk(0, '0, 1, 0, 16'h0200, '0, 0, 1));
        idle(1);
        vid_req = 1'b1; cpu_req = 1'b1;
        reset_n = 1'b0;
        #1 chk_all_zero("midreset");
        sb.delete();
        m_addr = '0; m_wdata = '0; m_we = 1'b0; m_vrd = '0; m_crd = '0;
        @(posedge clk);
        cyc++;
        #1;
        vid_req = 1'b0; cpu_req = 1'b0;
        reset_n = 1'b1;
        idle(4);
        step(mk(0, '0, 1, 0, 16'h1234, '0, 0, 1));
        idle(3);

        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
